rgb_process: RTL and testbench



---
 rtl/rgb_process_pkg.sv | 61 ++++++
 rtl/rgb_luma.sv | 27 ++
 rtl/rgb_process.sv | 109 ++++++++++
 tb/tb_rgb_process.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rgb_process_pkg.sv
// Shared constants and pixel type for the rgb_process colour post-processing stage.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package rgb_process_pkg;

  // Default frame geometry and overlay thickness.
  localparam int WIDTH_DEF  = 640;
  localparam int HEIGHT_DEF = 480;
  localparam int BORDER_DEF = 4;

  // filter_SW bit positions. Bit 3 is reserved and has no effect.
  localparam int SW_GRAY   = 0;
  localparam int SW_INV    = 1;
  localparam int SW_THRESH = 2;
  localparam int SW_RSVD   = 3;
  localparam int SW_BORDER = 4;
  localparam int SW_CROSS  = 5;

  // BT.601-style luma weights scaled by 256; they sum to 256, so the
  // 16-bit weighted sum of 8-bit channels never exceeds 255 << 8.
  localparam logic [15:0] LUMA_R = 16'd77;
  localparam logic [15:0] LUMA_G = 16'd150;
  localparam logic [15:0] LUMA_B = 16'd29;

  // Binarisation threshold: channels at or above this go to full scale.
  localparam logic [7:0] THRESH = 8'd128;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Overlay colours.
  localparam rgb_t BORDER_RGB = '{r: 8'd255, g: 8'd0,   b: 8'd0};
  localparam rgb_t CROSS_RGB  = '{r: 8'd0,   g: 8'd255, b: 8'd0};

  // Single-channel binarisation.
  function automatic logic [7:0] thresh_ch(input logic [7:0] x);
    return (x >= THRESH) ? 8'd255 : 8'd0;
  endfunction

  // Per-channel binarisation of a whole pixel.
  function automatic rgb_t thresh_px(input rgb_t p);
    rgb_t q;
    q.r = thresh_ch(p.r);
    q.g = thresh_ch(p.g);
    q.b = thresh_ch(p.b);
    return q;
  endfunction

  // Per-channel inversion (255 - x), which for 8 bits is a bitwise NOT.
  function automatic rgb_t invert_px(input rgb_t p);
    rgb_t q;
    q.r = ~p.r;
    q.g = ~p.g;
    q.b = ~p.b;
    return q;
  endfunction

endpackage

// File: rtl/rgb_luma.sv
// Combinational 8-bit RGB to 8-bit luma: Y = (77*R + 150*G + 29*B) >> 8.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the inputs continuously.
module rgb_luma
  import rgb_process_pkg::*;
(
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] y
);

  logic [15:0] acc;
  logic [7:0]  acc_frac;

  // Weighted sum in 16 bits; the weights sum to 256 so no overflow is possible.
  always_comb begin
    acc      = LUMA_R * {8'd0, r} + LUMA_G * {8'd0, g} + LUMA_B * {8'd0, b};
    y        = acc[15:8];
    acc_frac = acc[7:0];
  end

  // Truncation discards the fractional byte on purpose.
  logic unused_frac;
  assign unused_frac = ^acc_frac;

endmodule

// File: rtl/rgb_process.sv
// Per-pixel colour post-processing: grayscale, threshold, invert, then optional
// border/crosshair overlays (built only when RGB_PROCESS_OVERLAY_EN is defined).
// Latency: exactly 1 cycle, one pixel per cycle; no handshake, no backpressure.
module rgb_process
  import rgb_process_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int BORDER = BORDER_DEF
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  raw_VGA_R,
  input  logic [7:0]  raw_VGA_G,
  input  logic [7:0]  raw_VGA_B,
  input  logic [12:0] row,
  input  logic [12:0] col,
  input  logic [5:0]  filter_SW,
  output logic [7:0]  o_VGA_R,
  output logic [7:0]  o_VGA_G,
  output logic [7:0]  o_VGA_B
);

  rgb_t       px_in;
  rgb_t       px_gray;
  rgb_t       px_thresh;
  rgb_t       px_point;
  rgb_t       px_next;
  rgb_t       px_q;
  logic [7:0] luma;

  assign px_in = '{r: raw_VGA_R, g: raw_VGA_G, b: raw_VGA_B};

  rgb_luma u_luma (
    .r (px_in.r),
    .g (px_in.g),
    .b (px_in.b),
    .y (luma)
  );

  // Point filters in fixed order: grayscale, then threshold, then invert.
  always_comb begin
    px_gray   = filter_SW[SW_GRAY]   ? '{r: luma, g: luma, b: luma} : px_in;
    px_thresh = filter_SW[SW_THRESH] ? thresh_px(px_gray)           : px_gray;
    px_point  = filter_SW[SW_INV]    ? invert_px(px_thresh)         : px_thresh;
  end

`ifdef RGB_PROCESS_OVERLAY_EN
  localparam logic [12:0] W13      = 13'(WIDTH);
  localparam logic [12:0] H13      = 13'(HEIGHT);
  localparam logic [12:0] B13      = 13'(BORDER);
  localparam logic [12:0] MID_ROW  = 13'(HEIGHT / 2);
  localparam logic [12:0] MID_COL  = 13'(WIDTH / 2);
  localparam logic [12:0] ROW_LAST = 13'(HEIGHT - BORDER);
  localparam logic [12:0] COL_LAST = 13'(WIDTH - BORDER);

  logic in_frame;
  logic on_cross;
  logic on_border;

  // Coordinate decode; overlays only apply to pixels inside the active frame.
  always_comb begin
    in_frame  = (row < H13) && (col < W13);
    on_cross  = (row == MID_ROW) || (col == MID_COL);
    on_border = (row < B13) || (row >= ROW_LAST) ||
                (col < B13) || (col >= COL_LAST);
  end

  // Overlay select: crosshair outranks border, both replace the filtered pixel.
  always_comb begin
    px_next = px_point;
    if (in_frame) begin
      if (filter_SW[SW_CROSS] && on_cross) begin
        px_next = CROSS_RGB;
      end else if (filter_SW[SW_BORDER] && on_border) begin
        px_next = BORDER_RGB;
      end
    end
  end

  // The reserved switch is decoded but deliberately has no effect.
  logic unused_sw;
  assign unused_sw = filter_SW[SW_RSVD];
`else
  // Without overlays the filtered pixel goes straight to the output register.
  always_comb begin
    px_next = px_point;
  end

  // Coordinates, overlay switches and the reserved switch are not used here.
  logic unused_ovl;
  assign unused_ovl = ^{row, col, filter_SW[SW_CROSS], filter_SW[SW_BORDER],
                        filter_SW[SW_RSVD]};
`endif

  // Single output register; reset drops the in-flight pixel and drives black.
  always_ff @(posedge clk) begin
    if (reset) begin
      px_q <= '0;
    end else begin
      px_q <= px_next;
    end
  end

  assign o_VGA_R = px_q.r;
  assign o_VGA_G = px_q.g;
  assign o_VGA_B = px_q.b;

endmodule

// File: tb/tb_rgb_process.sv
// Directed-vector bench for rgb_process with a queue-based scoreboard.
// Expected pixels are hand-computed; overlay expectations follow RGB_PROCESS_OVERLAY_EN.
// The bench tracks its own 1-cycle valid pipeline since the DUT has no handshake.
module tb_rgb_process;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  raw_VGA_R, raw_VGA_G, raw_VGA_B;
  logic [12:0] row, col;
  logic [5:0]  filter_SW;
  logic [7:0]  o_VGA_R, o_VGA_G, o_VGA_B;

  typedef struct {
    logic [23:0] px;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic vld;
  logic vld_d;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rgb_process dut (
    .clk       (clk),
    .reset     (reset),
    .raw_VGA_R (raw_VGA_R),
    .raw_VGA_G (raw_VGA_G),
    .raw_VGA_B (raw_VGA_B),
    .row       (row),
    .col       (col),
    .filter_SW (filter_SW),
    .o_VGA_R   (o_VGA_R),
    .o_VGA_G   (o_VGA_G),
    .o_VGA_B   (o_VGA_B)
  );

  // Output of a vector issued before edge N is valid after edge N.
  always @(posedge clk) vld_d <= vld;

  // Monitor: pop and compare whenever the delayed valid says a result is present.
  always @(negedge clk) begin
    if (vld_d === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got %0d,%0d,%0d with empty scoreboard",
                 o_VGA_R, o_VGA_G, o_VGA_B);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_vec++;
        if ({o_VGA_R, o_VGA_G, o_VGA_B} !== e.px) begin
          n_bad++;
          $display("FAIL %s: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", e.name,
                   o_VGA_R, o_VGA_G, o_VGA_B, e.px[23:16], e.px[15:8], e.px[7:0]);
        end
      end
    end
  end

  // Drive one pixel for one cycle and register its expected result.
  task automatic apply(input logic rst, input logic [23:0] px, input int r, input int c,
                       input logic [5:0] sw, input logic [23:0] ex, input string nm);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    raw_VGA_R = px[23:16];
    raw_VGA_G = px[15:8];
    raw_VGA_B = px[7:0];
    row       = 13'(r);
    col       = 13'(c);
    filter_SW = sw;
    vld       = 1'b1;
    e.px      = ex;
    e.name    = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    vld   = 1'b0;
    reset = 1'b0;
  endtask

  localparam logic [23:0] P9     = {8'd9, 8'd9, 8'd9};
  localparam logic [23:0] RED    = {8'd255, 8'd0, 8'd0};
  localparam logic [23:0] GREEN  = {8'd0, 8'd255, 8'd0};
  localparam logic [5:0]  SW_OVL = 6'b110000;
`ifdef RGB_PROCESS_OVERLAY_EN
  localparam logic [23:0] EX_CROSS  = GREEN;
  localparam logic [23:0] EX_BORDER = RED;
`else
  localparam logic [23:0] EX_CROSS  = P9;
  localparam logic [23:0] EX_BORDER = P9;
`endif

  initial begin
    reset = 1'b1; vld = 1'b0; vld_d = 1'b0;
    raw_VGA_R = '0; raw_VGA_G = '0; raw_VGA_B = '0;
    row = '0; col = '0; filter_SW = '0;
    repeat (3) @(negedge clk);

    // Reset with a live pixel and arbitrary switches gives black.
    apply(1'b1, {8'd12, 8'd34, 8'd56}, 100, 100, 6'b010111, 24'd0, "reset_out");

    // Passthrough and back-to-back stream.
    apply(1'b0, {8'd12, 8'd34, 8'd56},   100, 100, 6'b000000, {8'd12, 8'd34, 8'd56}, "pass");
    apply(1'b0, {8'd1, 8'd2, 8'd3},      100, 101, 6'b000000, {8'd1, 8'd2, 8'd3}, "stream0");
    apply(1'b0, {8'd250, 8'd251, 8'd252},100, 102, 6'b000000, {8'd250, 8'd251, 8'd252}, "stream1");
    apply(1'b0, 24'd0,                   100, 103, 6'b000000, 24'd0, "stream2");
    apply(1'b0, 24'hFFFFFF,              100, 104, 6'b000000, 24'hFFFFFF, "stream3");
    apply(1'b0, {8'd77, 8'd88, 8'd99},   100, 105, 6'b001000, {8'd77, 8'd88, 8'd99}, "reserved_sw");

    // Point filters.
    apply(1'b0, {8'd100, 8'd150, 8'd200}, 100, 100, 6'b000001, {3{8'd140}}, "gray");
    apply(1'b0, 24'hFFFFFF,               100, 100, 6'b000001, 24'hFFFFFF, "gray_max");
    apply(1'b0, {8'd0, 8'd128, 8'd255},   100, 100, 6'b000010, {8'd255, 8'd127, 8'd0}, "invert");
    apply(1'b0, {8'd100, 8'd150, 8'd200}, 100, 100, 6'b000111, 24'd0, "gray_thr_inv");
    apply(1'b0, {8'd100, 8'd150, 8'd200}, 100, 100, 6'b000101, 24'hFFFFFF, "gray_thr");
    apply(1'b0, {8'd127, 8'd128, 8'd0},   100, 100, 6'b000100, {8'd0, 8'd255, 8'd0}, "thresh_edge");

    // Overlays.
    apply(1'b0, P9,   2, 320, SW_OVL, EX_CROSS,  "cross_over_border");
    apply(1'b0, P9,   2, 100, SW_OVL, EX_BORDER, "border_top");
    apply(1'b0, P9, 100, 636, SW_OVL, EX_BORDER, "border_right");
    apply(1'b0, P9, 100, 100, SW_OVL, P9,        "ovl_interior");
    apply(1'b0, P9, 500,   2, SW_OVL, P9,        "ovl_out_of_frame");
    apply(1'b0, P9, 476, 100, SW_OVL, EX_BORDER, "border_bottom_edge");
    apply(1'b0, P9, 475, 100, SW_OVL, P9,        "border_bottom_inside");
    apply(1'b0, P9, 100,   4, SW_OVL, P9,        "border_left_inside");
    apply(1'b0, P9, 240, 100, SW_OVL, EX_CROSS,  "cross_row");
    apply(1'b0, P9, 100, 100, 6'b110010, {3{8'd246}}, "ovl_miss_invert");

    // Switch change takes effect on the very next pixel.
    apply(1'b0, {3{8'd10}}, 100, 100, 6'b000000, {3{8'd10}},  "toggle_a");
    apply(1'b0, {3{8'd10}}, 100, 101, 6'b000010, {3{8'd245}}, "toggle_b");

    // Reset mid-stream discards the pixel; processing resumes right after.
    apply(1'b0, {8'd50, 8'd60, 8'd70}, 10, 10, 6'b000000, {8'd50, 8'd60, 8'd70}, "pre_reset");
    apply(1'b1, {8'd50, 8'd60, 8'd70}, 10, 11, 6'b000000, 24'd0, "mid_reset");
    apply(1'b0, {8'd1, 8'd1, 8'd1},    10, 12, 6'b000000, {8'd1, 8'd1, 8'd1}, "post_reset");
    idle();

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
